// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : scalar 16-bit and 96-beat bitmap load/store memory stage
// Rev 1.0
// ============================================================================
module mem_stage #(
   parameter int BM_WORDS = 96
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [15:0]            addr_in,
   input  logic [15:0]            st_data,
   input  logic [BM_WORDS*16-1:0] bd_in,
   input  logic                   ld,
   input  logic                   st,
   input  logic                   ldb,
   input  logic                   stb,
   input  logic                   reg_wr,
   input  logic                   bm_wr,
   input  logic [3:0]             rd_addr,
   input  logic [1:0]             bd_addr,
   output logic [15:0]            mem_addr,
   output logic [15:0]            mem_wdata,
   output logic                   mem_we,
   output logic                   mem_re,
   input  logic [15:0]            mem_rdata,
   output logic                   stall,
   output logic                   wb_valid,
   output logic [3:0]             wb_rd,
   output logic [15:0]            wb_data,
   output logic                   wb_bvalid,
   output logic [1:0]             wb_bd,
   output logic [BM_WORDS*16-1:0] wb_bdata
);
   localparam int              BM_W   = BM_WORDS * 16;
   localparam int              K_W    = $clog2(BM_WORDS + 1);
   localparam logic [K_W-1:0]  LAST_K = K_W'(BM_WORDS - 1);
   localparam logic [K_W-1:0]  ONE_K  = K_W'(1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LD_WAIT  = 3'd1,
      BRD      = 3'd2,
      BRD_LAST = 3'd3,
      BWR      = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [K_W-1:0]  k_q, k_d;
   logic [K_W-1:0]  beat;
   logic [15:0]     base_q, base_d;
   logic [3:0]      pend_rd_q, pend_rd_d;
   logic [1:0]      pend_bd_q, pend_bd_d;
   logic [BM_W-1:0] bm_q, bm_d;
   logic            wb_valid_q, wb_valid_d;
   logic [3:0]      wb_rd_q, wb_rd_d;
   logic [15:0]     wb_data_q, wb_data_d;
   logic            wb_bvalid_q, wb_bvalid_d;
   logic [1:0]      wb_bd_q, wb_bd_d;
   logic [BM_W-1:0] wb_bdata_q, wb_bdata_d;

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      base_d      = base_q;
      pend_rd_d   = pend_rd_q;
      pend_bd_d   = pend_bd_q;
      bm_d        = bm_q;
      wb_valid_d  = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      wb_bvalid_d = 1'b0;
      wb_bd_d     = wb_bd_q;
      wb_bdata_d  = wb_bdata_q;
      mem_addr    = addr_in;
      mem_wdata   = st_data;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      stall       = 1'b0;
      // read data arriving now belongs to the beat issued one cycle earlier
      beat        = k_q - ONE_K;

      case (state_q)
         IDLE: begin
            if (rst_n) begin
               if (ldb) begin
                  mem_re    = 1'b1;
                  stall     = 1'b1;
                  base_d    = addr_in;
                  pend_bd_d = bd_addr;
                  k_d       = ONE_K;
                  state_d   = BRD;
               end else if (stb) begin
                  mem_we    = 1'b1;
                  mem_wdata = bd_in[15:0];
                  stall     = 1'b1;
                  base_d    = addr_in;
                  bm_d      = bd_in;
                  k_d       = ONE_K;
                  state_d   = BWR;
               end else if (ld) begin
                  mem_re    = 1'b1;
                  stall     = 1'b1;
                  pend_rd_d = rd_addr;
                  state_d   = LD_WAIT;
               end else if (st) begin
                  mem_we    = 1'b1;
               end else begin
                  if (reg_wr) begin
                     wb_valid_d = 1'b1;
                     wb_rd_d    = rd_addr;
                     wb_data_d  = addr_in;
                  end
                  if (bm_wr) begin
                     wb_bvalid_d = 1'b1;
                     wb_bd_d     = bd_addr;
                     wb_bdata_d  = bd_in;
                  end
               end
            end
         end
         LD_WAIT: begin
            wb_valid_d = 1'b1;
            wb_rd_d    = pend_rd_q;
            wb_data_d  = mem_rdata;
            state_d    = IDLE;
         end
         BRD: begin
            mem_re                     = 1'b1;
            stall                      = 1'b1;
            mem_addr                   = base_q + 16'(k_q);
            bm_d[{beat, 4'b0000} +: 16] = mem_rdata;
            k_d                        = k_q + ONE_K;
            if (k_q == LAST_K) state_d = BRD_LAST;
         end
         BRD_LAST: begin
            bm_d[{beat, 4'b0000} +: 16] = mem_rdata;
            wb_bdata_d                 = bm_d;
            wb_bvalid_d                = 1'b1;
            wb_bd_d                    = pend_bd_q;
            k_d                        = '0;
            state_d                    = IDLE;
         end
         BWR: begin
            mem_we    = 1'b1;
            mem_addr  = base_q + 16'(k_q);
            mem_wdata = bm_q[{k_q, 4'b0000} +: 16];
            k_d       = k_q + ONE_K;
            // the final beat releases upstream so the next op lands with no bubble
            if (k_q == LAST_K) begin
               k_d     = '0;
               state_d = IDLE;
            end else begin
               stall   = 1'b1;
            end
         end
         default: begin
            k_d     = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         base_q      <= '0;
         pend_rd_q   <= '0;
         pend_bd_q   <= '0;
         bm_q        <= '0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         wb_bvalid_q <= 1'b0;
         wb_bd_q     <= '0;
         wb_bdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         base_q      <= base_d;
         pend_rd_q   <= pend_rd_d;
         pend_bd_q   <= pend_bd_d;
         bm_q        <= bm_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         wb_bvalid_q <= wb_bvalid_d;
         wb_bd_q     <= wb_bd_d;
         wb_bdata_q  <= wb_bdata_d;
      end
   end

   assign wb_valid  = wb_valid_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;
   assign wb_bvalid = wb_bvalid_q;
   assign wb_bd     = wb_bd_q;
   assign wb_bdata  = wb_bdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// tb_mem_stage : randomized self-checking bench for mem_stage, checked against
// a word-array memory model and per-operation expectations.
module tb_mem_stage;
   localparam int BM_WORDS = 96;
   localparam int BM_W     = BM_WORDS * 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [15:0]     addr_in, st_data;
   logic [BM_W-1:0] bd_in;
   logic            ld, st, ldb, stb, reg_wr, bm_wr;
   logic [3:0]      rd_addr;
   logic [1:0]      bd_addr;
   logic [15:0]     mem_addr, mem_wdata, mem_rdata;
   logic            mem_we, mem_re, stall;
   logic            wb_valid, wb_bvalid;
   logic [3:0]      wb_rd;
   logic [15:0]     wb_data;
   logic [1:0]      wb_bd;
   logic [BM_W-1:0] wb_bdata;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   mem_stage #(.BM_WORDS(BM_WORDS)) dut (
      .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .st_data(st_data), .bd_in(bd_in),
      .ld(ld), .st(st), .ldb(ldb), .stb(stb), .reg_wr(reg_wr), .bm_wr(bm_wr),
      .rd_addr(rd_addr), .bd_addr(bd_addr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .stall(stall),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_bvalid(wb_bvalid), .wb_bd(wb_bd), .wb_bdata(wb_bdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] bg(input logic [15:0] a);
      logic [15:0] t;
      t = a * 16'h9E37;
      return t ^ 16'h5A5A;
   endfunction

   // data memory attached to the DUT; background contents come from bg()
   logic [15:0] env_mem [0:65535];
   logic        env_init = 1'b0;
   always @(posedge clk) begin
      if (!env_init) begin
         for (int i = 0; i < 65536; i++) env_mem[i] <= bg(16'(i));
         env_init <= 1'b1;
      end else begin
         if (mem_we) env_mem[mem_addr] <= mem_wdata;
         if (mem_re) mem_rdata <= env_mem[mem_addr];
      end
   end

   // expected memory image, updated from the operations the bench issues
   logic [15:0] ref_mem [0:65535];

   typedef struct packed {int cyc; logic [15:0] a; logic [15:0] d;} acc_t;
   acc_t            we_log[$];
   acc_t            re_log[$];
   acc_t            ent;
   int              n_valid = 0, n_bvalid = 0, n_conflict = 0, v_cyc = 0, bv_cyc = 0;
   logic [15:0]     v_data;
   logic [3:0]      v_rd;
   logic [BM_W-1:0] bv_data;
   logic [1:0]      bv_bd;

   always @(negedge clk) begin
      if (mem_we) we_log.push_back(acc_t'{cyc, mem_addr, mem_wdata});
      if (mem_re) re_log.push_back(acc_t'{cyc, mem_addr, 16'h0000});
      if (mem_we && mem_re) n_conflict <= n_conflict + 1;
      if (wb_valid) begin
         n_valid <= n_valid + 1; v_cyc <= cyc; v_data <= wb_data; v_rd <= wb_rd;
      end
      if (wb_bvalid) begin
         n_bvalid <= n_bvalid + 1; bv_cyc <= cyc; bv_data <= wb_bdata; bv_bd <= wb_bd;
      end
   end

   function automatic logic [BM_W-1:0] rand_bm();
      logic [BM_W-1:0] r;
      for (int k = 0; k < BM_WORDS; k++) r[16*k +: 16] = 16'($urandom);
      return r;
   endfunction

   function automatic logic [BM_W-1:0] exp_bm(input logic [15:0] base);
      logic [BM_W-1:0] e;
      for (int k = 0; k < BM_WORDS; k++) e[16*k +: 16] = ref_mem[16'(base + 16'(k))];
      return e;
   endfunction

   task automatic ref_stb(input logic [15:0] base, input logic [BM_W-1:0] d);
      for (int k = 0; k < BM_WORDS; k++) ref_mem[16'(base + 16'(k))] = d[16*k +: 16];
   endtask

   function automatic int first_bad(input logic [BM_W-1:0] got, input logic [BM_W-1:0] e);
      for (int k = 0; k < BM_WORDS; k++) if (got[16*k +: 16] !== e[16*k +: 16]) return k;
      return -1;
   endfunction

   task automatic set_idle();
      {ldb, stb, ld, st} = 4'b0000;
      reg_wr = 1'b0; bm_wr = 1'b0;
      addr_in = 16'($urandom); st_data = 16'($urandom);
      rd_addr = 4'($urandom); bd_addr = 2'($urandom);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // present one op, hold it while stall is high, release after the first unstalled cycle
   task automatic run_op(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] sd,
                         input logic [BM_W-1:0] bd, input logic [3:0] rd, input logic [1:0] bda,
                         input logic rw, input logic bw, output int acc, output int nst);
      logic s;
      {ldb, stb, ld, st} = sel;
      addr_in = a; st_data = sd; bd_in = bd; rd_addr = rd; bd_addr = bda;
      reg_wr = rw; bm_wr = bw;
      acc = cyc; nst = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         s = stall;
         if (s) nst++;
         @(posedge clk); #1;
         if (!s) break;
      end
      set_idle();
   endtask

   task automatic test_reset();
      set_idle();
      ld = 1'b1;
      rst_n = 1'b0;
      idle_cycles(3);
      @(negedge clk);
      n_assert++;
      if ({stall, mem_we, mem_re, wb_valid, wb_bvalid, wb_rd, wb_bd, wb_data} !== 27'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: stall/we/re/v/bv/rd/bd/data got %b %b %b %b %b %h %h %h want all 0",
                  stall, mem_we, mem_re, wb_valid, wb_bvalid, wb_rd, wb_bd, wb_data);
      end
      n_assert++;
      if (wb_bdata !== '0) begin n_fail++; $display("FAIL reset_bdata: got nonzero want 0"); end
      @(posedge clk); #1;
      set_idle();
      rst_n = 1'b1;
      idle_cycles(2);
   endtask

   task automatic test_nonmem();
      int a0, n0, we0, re0, v0, bv0, w;
      logic [15:0] a; logic [3:0] rd; logic [1:0] bda; logic rw, bw; logic [BM_W-1:0] bd;
      for (int i = 0; i < 5; i++) begin
         if (i == 0) begin a = 16'h1234; rd = 4'd7; rw = 1'b1; bw = 1'b0; end
         else begin a = 16'($urandom); rd = 4'($urandom); rw = 1'($urandom); bw = 1'($urandom); end
         bd = rand_bm(); bda = 2'($urandom);
         we0 = we_log.size(); re0 = re_log.size(); v0 = n_valid; bv0 = n_bvalid;
         run_op(4'b0000, a, 16'($urandom), bd, rd, bda, rw, bw, a0, n0);
         idle_cycles(2);
         n_assert++;
         if (n0 != 0 || we_log.size() != we0 || re_log.size() != re0) begin
            n_fail++;
            $display("FAIL nonmem_quiet: stall=%0d we=%0d re=%0d want 0 0 0", n0,
                     we_log.size() - we0, re_log.size() - re0);
         end
         n_assert++;
         if (n_valid - v0 != int'(rw) || n_bvalid - bv0 != int'(bw)) begin
            n_fail++;
            $display("FAIL nonmem_pulses: valid=%0d bvalid=%0d want %0d %0d", n_valid - v0,
                     n_bvalid - bv0, rw, bw);
         end
         if (rw) begin
            n_assert++;
            if (v_cyc - a0 != 1 || v_rd !== rd || v_data !== a) begin
               n_fail++;
               $display("FAIL nonmem_wb: lat=%0d rd=%h data=%h want 1 %h %h", v_cyc - a0, v_rd, v_data, rd, a);
            end
         end
         if (bw) begin
            w = first_bad(bv_data, bd);
            n_assert++;
            if (bv_cyc - a0 != 1 || bv_bd !== bda || w >= 0) begin
               n_fail++;
               $display("FAIL nonmem_bwb: lat=%0d bd=%h bad_word=%0d want 1 %h -1", bv_cyc - a0, bv_bd, w, bda);
            end
         end
      end
   endtask

   task automatic test_st_ld();
      int a0, a1, n0, n1, we0, re0, v0;
      logic [15:0] sa, sd, la; logic [3:0] rd;
      for (int i = 0; i < 4; i++) begin
         if (i == 0) begin sa = 16'h0010; sd = 16'hBEEF; la = 16'h0010; rd = 4'd3; end
         else begin
            sa = 16'($urandom); sd = 16'($urandom); rd = 4'($urandom);
            la = (i == 2) ? 16'($urandom) : sa;
         end
         we0 = we_log.size(); re0 = re_log.size(); v0 = n_valid;
         run_op(4'b0001, sa, sd, rand_bm(), 4'($urandom), 2'($urandom), 1'b1, 1'b1, a0, n0);
         ref_mem[sa] = sd;
         run_op(4'b0010, la, 16'($urandom), rand_bm(), rd, 2'($urandom), 1'b1, 1'b1, a1, n1);
         idle_cycles(2);
         n_assert++;
         if (n0 != 0 || we_log.size() - we0 != 1) begin
            n_fail++; $display("FAIL st_write: stall=%0d writes=%0d want 0 1", n0, we_log.size() - we0);
         end else begin
            ent = we_log[we0];
            n_assert++;
            if (ent.cyc != a0 || ent.a !== sa || ent.d !== sd) begin
               n_fail++;
               $display("FAIL st_beat: cyc=%0d addr=%h data=%h want %0d %h %h", ent.cyc - a0, ent.a, ent.d, 0, sa, sd);
            end
         end
         n_assert++;
         if (n1 != 1 || re_log.size() - re0 != 1) begin
            n_fail++; $display("FAIL ld_read: stall=%0d reads=%0d want 1 1", n1, re_log.size() - re0);
         end else begin
            ent = re_log[re0];
            n_assert++;
            if (ent.cyc != a1 || ent.a !== la) begin
               n_fail++; $display("FAIL ld_addr: cyc=%0d addr=%h want 0 %h", ent.cyc - a1, ent.a, la);
            end
         end
         n_assert++;
         if (n_valid - v0 != 1 || v_cyc - a1 != 2 || v_rd !== rd || v_data !== ref_mem[la]) begin
            n_fail++;
            $display("FAIL ld_wb: pulses=%0d lat=%0d rd=%h data=%h want 1 2 %h %h", n_valid - v0,
                     v_cyc - a1, v_rd, v_data, rd, ref_mem[la]);
         end
      end
   endtask

   task automatic test_bitmap();
      logic [BM_W-1:0] pat;
      int a0, a1, n0, n1, we0, re0, bv0, bad, w;
      for (int k = 0; k < BM_WORDS; k++) pat[16*k +: 16] = 16'hA000 + 16'(k);
      we0 = we_log.size(); re0 = re_log.size(); bv0 = n_bvalid;
      run_op(4'b0100, 16'h0100, 16'($urandom), pat, 4'($urandom), 2'($urandom), 1'b0, 1'b0, a0, n0);
      ref_stb(16'h0100, pat);
      run_op(4'b1000, 16'h0100, 16'($urandom), rand_bm(), 4'($urandom), 2'd2, 1'b0, 1'b0, a1, n1);
      idle_cycles(2);
      n_assert++;
      if (n0 != 95 || we_log.size() - we0 != 96) begin
         n_fail++; $display("FAIL stb_count: stall=%0d writes=%0d want 95 96", n0, we_log.size() - we0);
      end else begin
         bad = 0;
         for (int k = 0; k < BM_WORDS; k++) begin
            ent = we_log[we0 + k];
            if (ent.cyc != a0 + k || ent.a !== 16'h0100 + 16'(k) || ent.d !== pat[16*k +: 16]) bad++;
         end
         n_assert++;
         if (bad != 0) begin n_fail++; $display("FAIL stb_beats: bad=%0d want 0", bad); end
      end
      n_assert++;
      if (n1 != 96 || re_log.size() - re0 != 96) begin
         n_fail++; $display("FAIL ldb_count: stall=%0d reads=%0d want 96 96", n1, re_log.size() - re0);
      end else begin
         bad = 0;
         for (int k = 0; k < BM_WORDS; k++) begin
            ent = re_log[re0 + k];
            if (ent.cyc != a1 + k || ent.a !== 16'h0100 + 16'(k)) bad++;
         end
         n_assert++;
         if (bad != 0) begin n_fail++; $display("FAIL ldb_beats: bad=%0d want 0", bad); end
      end
      w = first_bad(bv_data, exp_bm(16'h0100));
      n_assert++;
      if (n_bvalid - bv0 != 1 || bv_cyc - a1 != 97 || bv_bd !== 2'd2 || w >= 0) begin
         n_fail++;
         $display("FAIL ldb_wb: pulses=%0d lat=%0d bd=%h bad_word=%0d want 1 97 2 -1", n_bvalid - bv0,
                  bv_cyc - a1, bv_bd, w);
      end
      n_assert++;
      if (bv_data[95*16 +: 16] !== 16'hA05F) begin
         n_fail++; $display("FAIL ldb_word95: got %h want a05f", bv_data[95*16 +: 16]);
      end
   endtask

   task automatic test_wrap();
      int a1, n1, re0, bv0, bad, w;
      re0 = re_log.size(); bv0 = n_bvalid;
      run_op(4'b1000, 16'hFFF0, 16'($urandom), rand_bm(), 4'($urandom), 2'd1, 1'b1, 1'b1, a1, n1);
      idle_cycles(2);
      bad = 0;
      for (int k = 0; k < BM_WORDS; k++)
         if (re0 + k >= re_log.size() || re_log[re0 + k].a !== 16'(16'hFFF0 + 16'(k))) bad++;
      n_assert++;
      if (re_log.size() - re0 != 96 || bad != 0) begin
         n_fail++; $display("FAIL wrap_addr: reads=%0d bad=%0d want 96 0", re_log.size() - re0, bad);
      end
      n_assert++;
      if (bv_data[16*16 +: 16] !== ref_mem[16'h0000]) begin
         n_fail++; $display("FAIL wrap_word16: got %h want %h", bv_data[16*16 +: 16], ref_mem[16'h0000]);
      end
      w = first_bad(bv_data, exp_bm(16'hFFF0));
      n_assert++;
      if (n_bvalid - bv0 != 1 || bv_bd !== 2'd1 || w >= 0) begin
         n_fail++; $display("FAIL wrap_wb: pulses=%0d bd=%h bad_word=%0d want 1 1 -1", n_bvalid - bv0, bv_bd, w);
      end
   endtask

   task automatic test_priority();
      logic [BM_W-1:0] pat; logic [15:0] base;
      int a0, n0, we0, re0, v0, bv0, w;
      base = 16'($urandom); pat = rand_bm();
      we0 = we_log.size(); re0 = re_log.size(); v0 = n_valid; bv0 = n_bvalid;
      run_op(4'b0110, base, 16'($urandom), pat, 4'($urandom), 2'($urandom), 1'b1, 1'b1, a0, n0);
      ref_stb(base, pat);
      idle_cycles(3);
      n_assert++;
      if (n0 != 95 || we_log.size() - we0 != 96 || re_log.size() != re0 || n_valid != v0 || n_bvalid != bv0) begin
         n_fail++;
         $display("FAIL prio_stb_over_ld: stall=%0d we=%0d re=%0d v=%0d bv=%0d want 95 96 0 0 0", n0,
                  we_log.size() - we0, re_log.size() - re0, n_valid - v0, n_bvalid - bv0);
      end
      we0 = we_log.size(); re0 = re_log.size(); v0 = n_valid; bv0 = n_bvalid;
      run_op(4'b1111, base, 16'($urandom), rand_bm(), 4'($urandom), 2'd3, 1'b1, 1'b1, a0, n0);
      idle_cycles(2);
      w = first_bad(bv_data, pat);
      n_assert++;
      if (n0 != 96 || we_log.size() != we0 || re_log.size() - re0 != 96 || n_valid != v0 ||
          n_bvalid - bv0 != 1 || bv_bd !== 2'd3 || w >= 0) begin
         n_fail++;
         $display("FAIL prio_ldb_first: stall=%0d we=%0d re=%0d v=%0d bv=%0d bd=%h bad=%0d want 96 0 96 0 1 3 -1",
                  n0, we_log.size() - we0, re_log.size() - re0, n_valid - v0, n_bvalid - bv0, bv_bd, w);
      end
   endtask

   task automatic test_back_to_back();
      logic [BM_W-1:0] pat; logic [15:0] base; logic [3:0] rd;
      int a0, a1, n0, n1, v0;
      for (int i = 0; i < 2; i++) begin
         base = 16'($urandom); pat = rand_bm(); rd = 4'($urandom);
         v0 = n_valid;
         run_op(4'b0100, base, 16'($urandom), pat, 4'($urandom), 2'($urandom), 1'b0, 1'b0, a0, n0);
         ref_stb(base, pat);
         run_op(4'b0010, 16'(base + 16'(5 + i)), 16'($urandom), rand_bm(), rd, 2'($urandom), 1'b0, 1'b0, a1, n1);
         idle_cycles(2);
         n_assert++;
         if (a1 - a0 != 96 || n1 != 1 || n_valid - v0 != 1 || v_cyc - a1 != 2 || v_rd !== rd ||
             v_data !== pat[16*(5 + i) +: 16]) begin
            n_fail++;
            $display("FAIL b2b_stb_ld: gap=%0d stall=%0d v=%0d lat=%0d rd=%h data=%h want 96 1 1 2 %h %h",
                     a1 - a0, n1, n_valid - v0, v_cyc - a1, v_rd, v_data, rd, pat[16*(5 + i) +: 16]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int re0, bv0;
      re0 = re_log.size(); bv0 = n_bvalid;
      {ldb, stb, ld, st} = 4'b1000;
      addr_in = 16'($urandom); bd_addr = 2'($urandom);
      idle_cycles(40);
      rst_n = 1'b0;
      @(posedge clk); #1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_assert++;
         if (mem_re !== 1'b0 || mem_we !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: cycle %0d re=%b we=%b stall=%b want 0 0 0", c, mem_re, mem_we, stall);
         end
         @(posedge clk); #1;
      end
      set_idle();
      rst_n = 1'b1;
      idle_cycles(110);
      n_assert++;
      if (re_log.size() - re0 != 41 || n_bvalid != bv0) begin
         n_fail++;
         $display("FAIL reset_no_wb: reads=%0d bvalid=%0d want 41 0", re_log.size() - re0, n_bvalid - bv0);
      end
   endtask

   task automatic test_final();
      int bad;
      bad = 0;
      for (int i = 0; i < 65536; i++) if (env_mem[i] !== ref_mem[i]) bad++;
      n_assert++;
      if (bad != 0) begin n_fail++; $display("FAIL mem_image: mismatched words=%0d want 0", bad); end
      n_assert++;
      if (n_conflict != 0) begin n_fail++; $display("FAIL we_re_overlap: got %0d want 0", n_conflict); end
   endtask

   initial begin
      rst_n = 1'b0;
      bd_in = '0;
      set_idle();
      for (int i = 0; i < 65536; i++) ref_mem[i] = bg(16'(i));
      test_reset();
      test_nonmem();
      test_st_ld();
      test_bitmap();
      test_wrap();
      test_priority();
      test_back_to_back();
      test_reset_mid();
      test_final();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
